// File: rtl/fifo_pkg.sv
// fifo_pkg: Gray/binary pointer conversions shared by the read and write pointer blocks.
package fifo_pkg;
    localparam int PTR_MAX = 32;

    function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    // Zero-extended input is safe: leading zeros convert to leading zeros.
    function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
        logic [PTR_MAX-1:0] b;
        b[PTR_MAX-1] = g[PTR_MAX-1];
        for (int i = PTR_MAX - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
endpackage

// File: rtl/sync_w2r.sv
// sync_w2r: two-flop synchronizer carrying the Gray write pointer into the read clock domain.
module sync_w2r #(
    parameter int add_size = 3
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic [add_size:0] wr_ptr,
    output logic [add_size:0] wq2
);
    logic [add_size:0] wq1;

    always_ff @(posedge rd_clk) begin
        if (!rd_rst) begin
            wq1 <= '0;
            wq2 <= '0;
        end else begin
            wq1 <= wr_ptr;
            wq2 <= wq1;
        end
    end
endmodule

// File: rtl/rptr_empty.sv
// rptr_empty: FIFO read pointer, registered empty/almost-empty flags, fill level and sticky underflow.
module rptr_empty
    import fifo_pkg::*;
#(
    parameter int add_size  = 3,
    parameter int AE_THRESH = 1
) (
    input  logic                rd_clk,
    input  logic                rd_rst,
    input  logic                rd_inc,
    input  logic [add_size:0]   wr_ptr,
    output logic [add_size-1:0] rd_addr,
    output logic [add_size:0]   rd_ptr,
    output logic                empty,
    output logic                almost_empty,
    output logic [add_size:0]   rd_count,
    output logic                underflow
);
    localparam int W = add_size + 1;
    localparam logic [W-1:0] AE = W'(AE_THRESH);

    logic [W-1:0] rd_bin, rd_binnext, rd_graynext, wq2, wbin_sync, level;

    sync_w2r #(.add_size(add_size)) u_sync (
        .rd_clk(rd_clk),
        .rd_rst(rd_rst),
        .wr_ptr(wr_ptr),
        .wq2(wq2)
    );

    assign rd_binnext  = rd_bin + W'(rd_inc & ~empty);
    assign rd_graynext = W'(bin2gray(PTR_MAX'(rd_binnext)));
    assign wbin_sync   = W'(gray2bin(PTR_MAX'(wq2)));
    // Level uses the post-pop pointer so flags settle on the consuming edge.
    assign level       = wbin_sync - rd_binnext;
    assign rd_addr     = rd_bin[add_size-1:0];

    always_ff @(posedge rd_clk) begin
        if (!rd_rst) begin
            rd_bin       <= '0;
            rd_ptr       <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_count     <= '0;
            underflow    <= 1'b0;
        end else begin
            rd_bin       <= rd_binnext;
            rd_ptr       <= rd_graynext;
            empty        <= rd_graynext == wq2;
            almost_empty <= level <= AE;
            rd_count     <= level;
            underflow    <= underflow | (rd_inc & empty);
        end
    end
endmodule

// File: tb/tb_rptr_empty.sv
// tb_rptr_empty: directed checks of reset, sync latency, drain, wrap, underflow and mid-run reset.
module tb_rptr_empty;
    logic       rd_clk = 0;
    logic       rd_rst = 0;
    logic       rd_inc = 0;
    logic [3:0] wr_ptr = '0;
    logic [2:0] rd_addr;
    logic [3:0] rd_ptr;
    logic       empty;
    logic       almost_empty;
    logic [3:0] rd_count;
    logic       underflow;
    int checks = 0;
    int errors = 0;

    rptr_empty #(.add_size(3), .AE_THRESH(1)) dut (
        .rd_clk(rd_clk),
        .rd_rst(rd_rst),
        .rd_inc(rd_inc),
        .wr_ptr(wr_ptr),
        .rd_addr(rd_addr),
        .rd_ptr(rd_ptr),
        .empty(empty),
        .almost_empty(almost_empty),
        .rd_count(rd_count),
        .underflow(underflow)
    );

    always #5 rd_clk = ~rd_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge rd_clk);
        #1;
    endtask

    initial begin
        // Reset held for two edges
        tick(2);
        chk("rst_empty", empty, 1);
        chk("rst_ae", almost_empty, 1);
        chk("rst_ptr", rd_ptr, 4'b0000);
        chk("rst_addr", rd_addr, 0);
        chk("rst_count", rd_count, 0);
        chk("rst_uf", underflow, 0);
        rd_rst = 1;
        tick();
        chk("idle_empty", empty, 1);

        // One write: empty falls on the third edge
        wr_ptr = 4'b0001;
        tick(2);
        chk("lat2_empty", empty, 1);
        tick();
        chk("lat3_empty", empty, 0);
        chk("lat3_count", rd_count, 1);
        chk("lat3_ae", almost_empty, 1);

        // Full FIFO (gray 8) then drain 8 words
        wr_ptr = 4'b1100;
        tick(3);
        chk("full_count", rd_count, 8);
        chk("full_ae", almost_empty, 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_addr%0d", i), rd_addr, i);
            chk($sformatf("drain_empty%0d", i), empty, 0);
            rd_inc = 1;
            tick();
            rd_inc = 0;
        end
        chk("drain_empty", empty, 1);
        chk("drain_ptr", rd_ptr, 4'b1100);
        chk("drain_count", rd_count, 0);
        chk("drain_ae", almost_empty, 1);

        // Wrap pass (gray of 16 == 0000)
        wr_ptr = 4'b0000;
        tick(3);
        chk("wrap_count", rd_count, 8);
        rd_inc = 1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("wrap_addr%0d", i), rd_addr, i);
            tick();
        end
        rd_inc = 0;
        chk("wrap_ptr", rd_ptr, 4'b0000);
        chk("wrap_empty", empty, 1);
        chk("wrap_uf", underflow, 0);

        // Read while empty
        rd_inc = 1;
        tick();
        rd_inc = 0;
        chk("uf_ptr", rd_ptr, 4'b0000);
        chk("uf_set", underflow, 1);
        wr_ptr = 4'b0001;
        tick(3);
        chk("uf_wr_empty", empty, 0);
        rd_inc = 1;
        tick();
        rd_inc = 0;
        chk("uf_rd_ptr", rd_ptr, 4'b0001);
        chk("uf_sticky", underflow, 1);

        // Mid-operation reset with five words held (gray 6 = 0101)
        wr_ptr = 4'b0101;
        tick(3);
        chk("mid_count", rd_count, 5);
        rd_rst = 0;
        tick();
        rd_rst = 1;
        chk("mid_empty", empty, 1);
        chk("mid_ae", almost_empty, 1);
        chk("mid_ptr", rd_ptr, 0);
        chk("mid_addr", rd_addr, 0);
        chk("mid_count0", rd_count, 0);
        chk("mid_uf", underflow, 0);
        tick(2);
        chk("post2_empty", empty, 1);
        tick();
        chk("post3_empty", empty, 0);
        chk("post3_count", rd_count, 6);
        chk("post3_ae", almost_empty, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
